// File: rtl/priority_admit_pkg.sv
// Shared definitions for the priority admission block.
// Holds the parameter defaults, the width derivations for the class index
// and the aging counters, and the saturating add/subtract helper used by
// every per-class pending counter.
package priority_admit_pkg;

  localparam int N_CLASS_DEF = 3;
  localparam int CNT_W_DEF   = 8;
  localparam int AGE_LIM_DEF = 4;
  localparam int THRESH_DEF  = 16;

  // A single class still needs a one-bit index so the ports never collapse
  // to zero width.
  function automatic int clsWidth(input int nClass);
    return (nClass <= 2) ? 1 : $clog2(nClass);
  endfunction

  // Enough bits to hold the aging limit itself.
  function automatic int waitWidth(input int ageLim);
    return (ageLim < 1) ? 1 : $clog2(ageLim + 1);
  endfunction

  // base + addVal - subVal, floored at 0 and clamped at limit. The sum is
  // formed one bit wider so it cannot wrap before the clamp is applied.
  // Counters up to 31 bits wide fit through this helper.
  function automatic logic [31:0] satAddSub(input logic [31:0] base,
                                            input logic [31:0] addVal,
                                            input logic [31:0] subVal,
                                            input logic [31:0] limit);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, addVal};
    if (sum < {1'b0, subVal}) begin
      return '0;
    end
    sum = sum - {1'b0, subVal};
    if (sum > {1'b0, limit}) begin
      return limit;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/priority_admit_class_ctr.sv
// class_ctr: pending and aging state for one priority class.
// Ports:
//   i_clk, i_reset_n   clock and synchronous active-low reset
//   i_arr              arrivals for this class (already gated by arr_valid)
//   i_served           this class wins the service slot this cycle
//   i_srvEn            a service slot is offered this cycle
//   o_pending          registered pending count
//   o_nextPending      value pending takes at the next edge (for the total)
//   o_aged             wait counter has reached the aging limit
//   o_satHit           this cycle's update would exceed the counter range
module class_ctr
  import priority_admit_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int AGE_LIM = AGE_LIM_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [CNT_W-1:0] i_arr,
  input  logic             i_served,
  input  logic             i_srvEn,
  output logic [CNT_W-1:0] o_pending,
  output logic [CNT_W-1:0] o_nextPending,
  output logic             o_aged,
  output logic             o_satHit
);

  localparam int WAIT_W = waitWidth(AGE_LIM);
  localparam logic [CNT_W-1:0]  MAX_VAL = '1;
  localparam logic [WAIT_W-1:0] AGE_VAL = WAIT_W'(AGE_LIM);

  logic [CNT_W-1:0]  r_pending;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W:0]    w_ceiling;

  // Saturation means pending + arrivals - served lands above MAX_VAL; the
  // comparison is rearranged so nothing needs a signed intermediate.
  assign w_sum         = {1'b0, r_pending} + {1'b0, i_arr};
  assign w_ceiling     = {1'b0, MAX_VAL} + {{CNT_W{1'b0}}, i_served};
  assign o_satHit      = (w_sum > w_ceiling);
  assign o_nextPending = CNT_W'(satAddSub(32'(r_pending), 32'(i_arr),
                                          32'(i_served), 32'(MAX_VAL)));

  // Wait counts offered-but-lost slots while work is pending and is
  // cleared as soon as the class is served or has nothing pending.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pending <= '0;
      r_wait    <= '0;
    end else begin
      r_pending <= o_nextPending;
      if (i_served || (r_pending == '0)) begin
        r_wait <= '0;
      end else if (i_srvEn && (r_wait != AGE_VAL)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
    end
  end

  assign o_pending = r_pending;
  assign o_aged    = (r_wait == AGE_VAL);

endmodule

// File: rtl/priority_admit.sv
// priority_admit: strict-priority service arbiter with aging, per-class
// pending counters, a congestion flag and a sticky saturation flag.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   arr_valid      arr_cnt carries valid arrivals this cycle
//   arr_cnt        packed per-class arrival counts, class i at [i*CNT_W +: CNT_W]
//   srv_en         one service slot offered this cycle
//   srv_valid      registered: a request was served on the last edge
//   srv_class      registered: class served, 0 when nothing was served
//   pend_total     registered sum of all pending counters
//   res            registered congestion flag, pend_total >= THRESH
//   ovf            sticky: some pending counter saturated since reset
module priority_admit
  import priority_admit_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int AGE_LIM = AGE_LIM_DEF,
  parameter int THRESH  = THRESH_DEF,
  localparam int CLS_W  = clsWidth(N_CLASS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arr_valid,
  input  logic [N_CLASS*CNT_W-1:0] arr_cnt,
  input  logic                     srv_en,
  output logic                     srv_valid,
  output logic [CLS_W-1:0]         srv_class,
  output logic [CNT_W+CLS_W-1:0]   pend_total,
  output logic                     res,
  output logic                     ovf
);

  localparam int TOT_W = CNT_W + CLS_W;

  logic [CNT_W-1:0] w_pending     [N_CLASS];
  logic [CNT_W-1:0] w_nextPending [N_CLASS];
  logic [N_CLASS-1:0] w_eligible;
  logic [N_CLASS-1:0] w_aged;
  logic [N_CLASS-1:0] w_satHit;
  logic [N_CLASS-1:0] w_served;

  logic             w_anyElig;
  logic             w_anyAged;
  logic [CLS_W-1:0] w_normClass;
  logic [CLS_W-1:0] w_agedClass;
  logic [CLS_W-1:0] w_selClass;
  logic             w_grant;
  logic [TOT_W-1:0] w_nextTotal;

  logic             r_srvValid;
  logic [CLS_W-1:0] r_srvClass;
  logic [TOT_W-1:0] r_pendTotal;
  logic             r_res;
  logic             r_ovf;

  for (genvar g = 0; g < N_CLASS; g++) begin : gen_class
    class_ctr #(
      .CNT_W  (CNT_W),
      .AGE_LIM(AGE_LIM)
    ) u_ctr (
      .i_clk        (clk),
      .i_reset_n    (reset_n),
      .i_arr        (arr_valid ? arr_cnt[g*CNT_W +: CNT_W] : '0),
      .i_served     (w_served[g]),
      .i_srvEn      (srv_en),
      .o_pending    (w_pending[g]),
      .o_nextPending(w_nextPending[g]),
      .o_aged       (w_aged[g]),
      .o_satHit     (w_satHit[g])
    );
    assign w_eligible[g] = |w_pending[g];
    assign w_served[g]   = w_grant && (w_selClass == CLS_W'(g));
  end

  // Ascending scan so the last hit is the highest index; an aged eligible
  // class overrides plain priority. Only registered state feeds this, so
  // same-cycle arrivals cannot win the slot.
  always_comb begin
    w_anyElig   = 1'b0;
    w_anyAged   = 1'b0;
    w_normClass = '0;
    w_agedClass = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (w_eligible[i]) begin
        w_anyElig   = 1'b1;
        w_normClass = CLS_W'(i);
        if (w_aged[i]) begin
          w_anyAged   = 1'b1;
          w_agedClass = CLS_W'(i);
        end
      end
    end
    w_selClass = w_anyAged ? w_agedClass : w_normClass;
  end

  assign w_grant = srv_en && w_anyElig;

  // Total of the post-update counters so pend_total and res move on the
  // same edge as the counters themselves.
  always_comb begin
    w_nextTotal = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      w_nextTotal = w_nextTotal + TOT_W'(w_nextPending[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_srvValid  <= 1'b0;
      r_srvClass  <= '0;
      r_pendTotal <= '0;
      r_res       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_srvValid  <= w_grant;
      r_srvClass  <= w_grant ? w_selClass : '0;
      r_pendTotal <= w_nextTotal;
      r_res       <= (w_nextTotal >= TOT_W'(THRESH));
      r_ovf       <= r_ovf | (|w_satHit);
    end
  end

  assign srv_valid  = r_srvValid;
  assign srv_class  = r_srvClass;
  assign pend_total = r_pendTotal;
  assign res        = r_res;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_priority_admit.sv
// Testbench for priority_admit with default parameters (3 classes, 8-bit
// counters, aging limit 4, threshold 16). A behavioural model tracks
// pending counts and wait ages as plain integers and predicts every output
// after each edge; directed scenarios add literal expectations, then a
// long randomized run exercises resets, bursts and saturation.
module tb_priority_admit;

  localparam int NC   = 3;
  localparam int CW   = 8;
  localparam int AGE  = 4;
  localparam int TH   = 16;
  localparam int MAXV = 255;

  logic        clk;
  logic        reset_n;
  logic        arr_valid;
  logic [23:0] arr_cnt;
  logic        srv_en;
  logic        srv_valid;
  logic [1:0]  srv_class;
  logic [9:0]  pend_total;
  logic        res;
  logic        ovf;

  priority_admit #(
    .N_CLASS(NC),
    .CNT_W  (CW),
    .AGE_LIM(AGE),
    .THRESH (TH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .arr_valid (arr_valid),
    .arr_cnt   (arr_cnt),
    .srv_en    (srv_en),
    .srv_valid (srv_valid),
    .srv_class (srv_class),
    .pend_total(pend_total),
    .res       (res),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    nVectors = 0;
  int    nMis     = 0;
  string phase    = "init";

  int mPend [NC];
  int mWait [NC];
  bit mOvf;
  bit expValid;
  int expClass;
  int expTotal;
  bit expRes;

  function automatic logic [23:0] pack3(input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d", phase, name, act, exp);
    end
  endtask

  // Advances the model by one edge from the rules: pick the highest aged
  // eligible class, else the highest eligible class, using only state from
  // before the edge; then apply arrivals and service together with clamping.
  task automatic modelUpdate(input bit rstN, input bit av, input logic [23:0] cnt, input bit en);
    int pick;
    int agedPick;
    int arrI;
    int nv;
    if (!rstN) begin
      for (int i = 0; i < NC; i++) begin
        mPend[i] = 0;
        mWait[i] = 0;
      end
      mOvf = 0; expValid = 0; expClass = 0; expTotal = 0; expRes = 0;
      return;
    end
    pick = -1;
    agedPick = -1;
    for (int i = 0; i < NC; i++) begin
      if (mPend[i] > 0) pick = i;
      if (mPend[i] > 0 && mWait[i] == AGE) agedPick = i;
    end
    if (agedPick >= 0) pick = agedPick;
    if (!en) pick = -1;
    expValid = (pick >= 0);
    expClass = (pick >= 0) ? pick : 0;
    expTotal = 0;
    for (int i = 0; i < NC; i++) begin
      arrI = av ? int'(cnt[i*CW +: CW]) : 0;
      if (pick == i || mPend[i] == 0) mWait[i] = 0;
      else if (en && mWait[i] < AGE) mWait[i] = mWait[i] + 1;
      nv = mPend[i] + arrI - ((pick == i) ? 1 : 0);
      if (nv > MAXV) begin
        nv = MAXV;
        mOvf = 1;
      end
      mPend[i] = nv;
      expTotal += nv;
    end
    expRes = (expTotal >= TH);
  endtask

  task automatic checkOutput();
    checkField("srv_valid",  32'(srv_valid),  32'(expValid));
    checkField("srv_class",  32'(srv_class),  32'(expClass));
    checkField("pend_total", 32'(pend_total), 32'(expTotal));
    checkField("res",        32'(res),        32'(expRes));
    checkField("ovf",        32'(ovf),        32'(mOvf));
  endtask

  // Inputs change 1 time unit after an edge, so they are stable across the
  // next rising edge; outputs are sampled 1 time unit after it.
  task automatic applyStimulus(input bit rstN, input bit av, input logic [23:0] cnt, input bit en);
    reset_n   = rstN;
    arr_valid = av;
    arr_cnt   = cnt;
    srv_en    = en;
    @(posedge clk);
    modelUpdate(rstN, av, cnt, en);
    #1;
    checkOutput();
  endtask

  initial begin
    int seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit rRst;
    bit rAv;
    bit rEn;
    int c [NC];

    reset_n = 1'b0; arr_valid = 1'b0; arr_cnt = '0; srv_en = 1'b0;
    #1;

    phase = "reset";
    applyStimulus(0, 1, pack3(3, 2, 1), 1);
    applyStimulus(0, 1, pack3(3, 2, 1), 1);
    checkField("lit pend_total", 32'(pend_total), 0);
    checkField("lit srv_valid",  32'(srv_valid),  0);
    checkField("lit ovf",        32'(ovf),        0);
    applyStimulus(1, 0, '0, 1);
    checkField("lit idle srv_valid", 32'(srv_valid), 0);

    phase = "aging";
    applyStimulus(1, 1, pack3(5, 8, 0), 0);
    checkField("lit pend_total", 32'(pend_total), 13);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, '0, 1);
      checkField("lit srv_class", 32'(srv_class), 32'(seq[k]));
    end
    checkField("lit final pend_total", 32'(pend_total), 3);

    phase = "saturation";
    applyStimulus(0, 0, '0, 0);
    applyStimulus(1, 1, pack3(0, 0, 200), 0);
    applyStimulus(1, 1, pack3(0, 0, 200), 0);
    checkField("lit pend_total", 32'(pend_total), 255);
    checkField("lit ovf",        32'(ovf),        1);
    applyStimulus(1, 0, '0, 1);
    checkField("lit srv_class",  32'(srv_class),  2);
    checkField("lit after pend_total", 32'(pend_total), 254);
    applyStimulus(1, 0, '0, 0);
    checkField("lit sticky ovf", 32'(ovf), 1);

    phase = "threshold";
    applyStimulus(0, 0, '0, 0);
    applyStimulus(1, 1, pack3(6, 5, 5), 0);
    checkField("lit res",        32'(res),        1);
    checkField("lit pend_total", 32'(pend_total), 16);
    applyStimulus(1, 0, '0, 1);
    checkField("lit pend_total 15", 32'(pend_total), 15);
    checkField("lit res low",       32'(res),        0);

    phase = "simultaneous";
    applyStimulus(0, 0, '0, 0);
    applyStimulus(1, 1, pack3(0, 3, 0), 0);
    applyStimulus(1, 1, pack3(0, 1, 0), 1);
    checkField("lit srv_class",  32'(srv_class),  1);
    checkField("lit pend_total", 32'(pend_total), 3);

    phase = "midrun_reset";
    applyStimulus(0, 0, '0, 0);
    applyStimulus(1, 1, pack3(5, 8, 0), 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, '0, 1);
    applyStimulus(0, 1, pack3(4, 4, 4), 1);
    checkField("lit srv_valid",  32'(srv_valid),  0);
    checkField("lit pend_total", 32'(pend_total), 0);
    applyStimulus(1, 0, '0, 1);
    checkField("lit idle srv_valid", 32'(srv_valid), 0);
    applyStimulus(1, 1, pack3(2, 0, 0), 1);
    checkField("lit same-cycle srv_valid", 32'(srv_valid), 0);
    applyStimulus(1, 0, '0, 1);
    checkField("lit resume srv_valid", 32'(srv_valid), 1);
    checkField("lit resume srv_class", 32'(srv_class), 0);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      rRst = ($urandom_range(0, 99) != 0);
      rAv  = ($urandom_range(0, 2) == 0);
      rEn  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NC; i++) begin
        c[i] = $urandom_range(0, 2);
        if ($urandom_range(0, 199) == 0) c[i] = $urandom_range(128, 255);
      end
      applyStimulus(rRst, rAv, pack3(c[0], c[1], c[2]), rEn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMis);
    $finish;
  end

endmodule
